// File: rtl/jk_mod_counter_pkg.sv
// Shared definitions for the JK-based modulo counter: JK command encodings
// and default counter geometry.
package jk_mod_counter_pkg;

  // {j, k} command applied to a JK cell on a clock edge.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 10;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset and the full JK
// truth table (hold, reset, set, toggle).
module jk_cell
  import jk_mod_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case (jk_cmd_e'({j, k}))
        JK_HOLD:   q <= q;
        JK_RESET:  q <= 1'b0;
        JK_SET:    q <= 1'b1;
        JK_TOGGLE: q <= ~q;
      endcase
    end
  end

  assign qn = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Loadable modulo-N up/down counter whose storage is one jk_cell per bit,
// excited with hold/set/reset only. Provides terminal count, wrap and
// out-of-range-load indications.
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Largest legal count; comparing against this instead of MODULUS keeps all
  // arithmetic inside WIDTH bits even when MODULUS = 2**WIDTH.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic [WIDTH-1:0] qn_vec;
  logic             load_ok;
  logic             at_top;
  logic             at_bottom;

  assign load_ok   = (d <= MAX_CNT);
  assign at_top    = (q == MAX_CNT);
  assign at_bottom = (q == '0);

  assign tc = en && !load && !rst && ((up && at_top) || (!up && at_bottom));

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    nxt = q;
    if (load) begin
      nxt = load_ok ? d : '0;
    end else if (en) begin
      if (up) begin
        // Out-of-range values also fold back to zero when counting up.
        nxt = (q >= MAX_CNT) ? '0 : q + WIDTH'(1);
      end else begin
        nxt = at_bottom ? MAX_CNT : q - WIDTH'(1);
      end
    end
  end

  // Drive each cell with set or reset only where the bit must change.
  assign j_vec = nxt & qn_vec;
  assign k_vec = ~nxt & q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_vec[i]),
      .k   (k_vec[i]),
      .q   (q[i]),
      .qn  (qn_vec[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= tc;
      load_err <= load && !load_ok;
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter (WIDTH = 4, MODULUS = 10): a modular
// arithmetic reference model predicts each edge, results are compared after it.
module tb_jk_mod_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  typedef struct {
    int q;
    int wrap;
    int load_err;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             en;
  logic             load;
  logic             up;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             load_err;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mq       = 0;

  jk_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .up       (up),
    .d        (d),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check the pre-edge combinational outputs,
  // push the model's prediction, then compare after the edge.
  task automatic step(input logic r, input logic ld, input logic e, input logic u,
                      input int dv, input bit check_hold_jk = 0);
    exp_t e_item;
    int   exp_tc;
    rst  = r;
    load = ld;
    en   = e;
    up   = u;
    d    = WIDTH'(dv);
    #1;
    exp_tc = (!r && !ld && e && ((u && mq == MODULUS - 1) || (!u && mq == 0))) ? 1 : 0;
    if (!r) check("tc", 32'(tc), 32'(exp_tc));
    if (check_hold_jk) begin
      check("j_hold", 32'(dut.j_vec), 32'd0);
      check("k_hold", 32'(dut.k_vec), 32'd0);
    end
    e_item.wrap     = 0;
    e_item.load_err = 0;
    if (r) begin
      mq = 0;
    end else if (ld) begin
      if (dv < MODULUS) mq = dv;
      else begin
        mq = 0;
        e_item.load_err = 1;
      end
    end else if (e) begin
      e_item.wrap = exp_tc;
      if (u) mq = (mq + 1) % MODULUS;
      else   mq = (mq + MODULUS - 1) % MODULUS;
    end
    e_item.q = mq;
    exp_q.push_back(e_item);
    @(posedge clk);
    #1;
    e_item = exp_q.pop_front();
    check("q", 32'(q), 32'(e_item.q));
    check("wrap", 32'(wrap), 32'(e_item.wrap));
    check("load_err", 32'(load_err), 32'(e_item.load_err));
    check("no_toggle", 32'(dut.j_vec & dut.k_vec), 32'd0);
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; d = '0;
    @(negedge clk);

    // Reset; outputs must all be zero afterwards.
    step(1, 0, 0, 0, 0);

    // Count up through the wrap: 1..9, 0, 1, 2.
    for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0);

    // Back to 0, then count down: 9, 8, 7.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

    // Load beats enable; out-of-range load clears q and flags for one cycle.
    step(0, 1, 1, 1, 7);
    step(0, 1, 1, 0, 12);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 9);
    step(0, 1, 0, 0, 10);
    step(0, 1, 0, 0, 15);

    // Hold at 4 for five cycles with all JK pairs idle.
    step(0, 1, 0, 0, 4);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 1);

    // Reset wins over a simultaneous load.
    step(0, 1, 0, 0, 8);
    step(1, 1, 1, 1, 5);

    // Direction flip at the boundary gives back-to-back wraps.
    step(0, 1, 0, 0, 9);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);

    // Mixed random traffic.
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
